tcp_ptr_if_ctrl_multi: RTL and testbench



---
 rtl/tcp_ptr_if_ctrl_multi.sv | 183 ++++++++++++++++++
 tb/tb_tcp_ptr_if_ctrl_multi.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_ptr_if_ctrl_multi.sv
// tcp_ptr_if_ctrl_multi
// Control FSM for the NoC pointer interface of a TCP buffer tile, serving
// NUM_PTRS pointer tables. It accepts one request header flit, then reads or
// writes the masked subset of tables with independent per-table handshakes.
// Reads return one response header flit. The flit decode, pointer storage and
// flit build live in a companion datapath that is driven by ctrl_datap_* strobes.
// Optional feature macro: TCP_PTR_IF_WR_ACK_EN. When it is defined, writes
// (including zero-mask writes) return an ack flit from the WR_ACK state.
module tcp_ptr_if_ctrl_multi #(
    parameter int NUM_PTRS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                noc_ctovr_val,
    input  logic                noc_ctovr_is_rd,
    input  logic [NUM_PTRS-1:0] noc_ctovr_ptr_mask,
    output logic                noc_ctovr_rdy,
    output logic                noc_vrtoc_val,
    input  logic                noc_vrtoc_rdy,
    output logic [NUM_PTRS-1:0] ptr_wr_req_val,
    input  logic [NUM_PTRS-1:0] ptr_wr_req_rdy,
    output logic [NUM_PTRS-1:0] ptr_rd_req_val,
    input  logic [NUM_PTRS-1:0] ptr_rd_req_rdy,
    input  logic [NUM_PTRS-1:0] ptr_rd_resp_val,
    output logic [NUM_PTRS-1:0] ptr_rd_resp_rdy,
    output logic                ctrl_datap_store_hdr_flit,
    output logic [NUM_PTRS-1:0] ctrl_datap_store_ptr,
    output logic                ctrl_datap_resp_is_ack
);

    typedef enum logic [2:0] {
        ST_READY,
        ST_RD_PTRS,
        ST_WR_PTRS,
        ST_RESP_FLIT
`ifdef TCP_PTR_IF_WR_ACK_EN
        , ST_WR_ACK
`endif
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NUM_PTRS-1:0] r_mask;
    logic [NUM_PTRS-1:0] r_req_done;
    logic [NUM_PTRS-1:0] r_resp_done;

    logic [NUM_PTRS-1:0] w_wr_req_val;
    logic [NUM_PTRS-1:0] w_rd_req_val;
    logic [NUM_PTRS-1:0] w_rd_resp_rdy;
    logic [NUM_PTRS-1:0] w_wr_hs;
    logic [NUM_PTRS-1:0] w_rd_req_hs;
    logic [NUM_PTRS-1:0] w_rd_resp_hs;
    logic                w_hdr_hs;
    logic                w_wr_all_done;
    logic                w_rd_all_done;
    logic                w_ctovr_rdy;
    logic                w_vrtoc_val;
`ifdef TCP_PTR_IF_WR_ACK_EN
    logic                w_resp_is_ack;
`endif

    // Per-table requests stay up until that table has handshaken. A response is
    // only accepted after its own request has completed in an earlier cycle.
    assign w_wr_req_val  = (r_state == ST_WR_PTRS) ? (r_mask & ~r_req_done) : '0;
    assign w_rd_req_val  = (r_state == ST_RD_PTRS) ? (r_mask & ~r_req_done) : '0;
    assign w_rd_resp_rdy = (r_state == ST_RD_PTRS) ? (r_mask & r_req_done & ~r_resp_done) : '0;

    assign w_wr_hs      = w_wr_req_val & ptr_wr_req_rdy;
    assign w_rd_req_hs  = w_rd_req_val & ptr_rd_req_rdy;
    assign w_rd_resp_hs = w_rd_resp_rdy & ptr_rd_resp_val;
    assign w_hdr_hs     = (r_state == ST_READY) & noc_ctovr_val;

    // Completion includes the handshakes landing this cycle, so the last table
    // to finish moves the FSM on without an extra idle cycle.
    assign w_wr_all_done = ((r_req_done | w_wr_hs) == r_mask);
    assign w_rd_all_done = ((r_resp_done | w_rd_resp_hs) == r_mask);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state control outputs.
    // NOTE: every variable gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_ctovr_rdy   = 1'b0;
        w_vrtoc_val   = 1'b0;
`ifdef TCP_PTR_IF_WR_ACK_EN
        w_resp_is_ack = 1'b0;
`endif
        case (r_state)
            ST_READY: begin
                w_ctovr_rdy = 1'b1;
                if (noc_ctovr_val) begin
                    if (noc_ctovr_is_rd) begin
                        w_state_nxt = (|noc_ctovr_ptr_mask) ? ST_RD_PTRS : ST_RESP_FLIT;
                    end else if (|noc_ctovr_ptr_mask) begin
                        w_state_nxt = ST_WR_PTRS;
                    end else begin
`ifdef TCP_PTR_IF_WR_ACK_EN
                        w_state_nxt = ST_WR_ACK;
`else
                        w_state_nxt = ST_READY;
`endif
                    end
                end
            end
            ST_WR_PTRS: begin
                if (w_wr_all_done) begin
`ifdef TCP_PTR_IF_WR_ACK_EN
                    w_state_nxt = ST_WR_ACK;
`else
                    w_state_nxt = ST_READY;
`endif
                end
            end
            ST_RD_PTRS: begin
                if (w_rd_all_done) begin
                    w_state_nxt = ST_RESP_FLIT;
                end
            end
            ST_RESP_FLIT: begin
                w_vrtoc_val = 1'b1;
                if (noc_vrtoc_rdy) begin
                    w_state_nxt = ST_READY;
                end
            end
`ifdef TCP_PTR_IF_WR_ACK_EN
            ST_WR_ACK: begin
                w_vrtoc_val   = 1'b1;
                w_resp_is_ack = 1'b1;
                if (noc_vrtoc_rdy) begin
                    w_state_nxt = ST_READY;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_READY;
            end
        endcase
    end

    // Request mask and per-table progress; a new header restarts the tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask      <= '0;
            r_req_done  <= '0;
            r_resp_done <= '0;
        end else if (w_hdr_hs) begin
            r_mask      <= noc_ctovr_ptr_mask;
            r_req_done  <= '0;
            r_resp_done <= '0;
        end else begin
            r_req_done  <= r_req_done | w_wr_hs | w_rd_req_hs;
            r_resp_done <= r_resp_done | w_rd_resp_hs;
        end
    end

    // Outputs are forced low while reset is held. Without this, the READY state
    // entered by reset would advertise header accept during reset.
    assign noc_ctovr_rdy             = rst_n & w_ctovr_rdy;
    assign noc_vrtoc_val             = rst_n & w_vrtoc_val;
    assign ptr_wr_req_val            = {NUM_PTRS{rst_n}} & w_wr_req_val;
    assign ptr_rd_req_val            = {NUM_PTRS{rst_n}} & w_rd_req_val;
    assign ptr_rd_resp_rdy           = {NUM_PTRS{rst_n}} & w_rd_resp_rdy;
    assign ctrl_datap_store_hdr_flit = rst_n & w_hdr_hs;
    assign ctrl_datap_store_ptr      = {NUM_PTRS{rst_n}} & w_rd_resp_hs;
`ifdef TCP_PTR_IF_WR_ACK_EN
    assign ctrl_datap_resp_is_ack    = rst_n & w_resp_is_ack;
`else
    assign ctrl_datap_resp_is_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_tcp_ptr_if_ctrl_multi.sv
// tb_tcp_ptr_if_ctrl_multi
// Directed and random stimulus for tcp_ptr_if_ctrl_multi with NUM_PTRS=2.
// A transaction-level model tracks which tables each request wants, which have
// been issued and which have returned, and predicts every output each cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled just after the falling edge.
module tb_tcp_ptr_if_ctrl_multi;
    localparam int N = 2;
`ifdef TCP_PTR_IF_WR_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         noc_ctovr_val;
    logic         noc_ctovr_is_rd;
    logic [N-1:0] noc_ctovr_ptr_mask;
    logic         noc_ctovr_rdy;
    logic         noc_vrtoc_val;
    logic         noc_vrtoc_rdy;
    logic [N-1:0] ptr_wr_req_val;
    logic [N-1:0] ptr_wr_req_rdy;
    logic [N-1:0] ptr_rd_req_val;
    logic [N-1:0] ptr_rd_req_rdy;
    logic [N-1:0] ptr_rd_resp_val;
    logic [N-1:0] ptr_rd_resp_rdy;
    logic         ctrl_datap_store_hdr_flit;
    logic [N-1:0] ctrl_datap_store_ptr;
    logic         ctrl_datap_resp_is_ack;

    tcp_ptr_if_ctrl_multi #(.NUM_PTRS(N)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .noc_ctovr_val             (noc_ctovr_val),
        .noc_ctovr_is_rd           (noc_ctovr_is_rd),
        .noc_ctovr_ptr_mask        (noc_ctovr_ptr_mask),
        .noc_ctovr_rdy             (noc_ctovr_rdy),
        .noc_vrtoc_val             (noc_vrtoc_val),
        .noc_vrtoc_rdy             (noc_vrtoc_rdy),
        .ptr_wr_req_val            (ptr_wr_req_val),
        .ptr_wr_req_rdy            (ptr_wr_req_rdy),
        .ptr_rd_req_val            (ptr_rd_req_val),
        .ptr_rd_req_rdy            (ptr_rd_req_rdy),
        .ptr_rd_resp_val           (ptr_rd_resp_val),
        .ptr_rd_resp_rdy           (ptr_rd_resp_rdy),
        .ctrl_datap_store_hdr_flit (ctrl_datap_store_hdr_flit),
        .ctrl_datap_store_ptr      (ctrl_datap_store_ptr),
        .ctrl_datap_resp_is_ack    (ctrl_datap_resp_is_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_bad   = 0;
    int n_dut_flits = 0;

    // Transaction-level reference model.
    typedef enum int {M_IDLE, M_RD, M_WR, M_RSP, M_ACK} mphase_t;
    mphase_t m_ph;
    bit      m_want[N];
    bit      m_issued[N];
    bit      m_returned[N];
    int      m_flits = 0;

    // Expected and sampled outputs for the current cycle.
    logic         e_ctovr_rdy, e_hdr, e_vrtoc, e_ack;
    logic [N-1:0] e_wr, e_rd, e_rrdy, e_store;
    logic         s_ctovr_rdy, s_hdr, s_vrtoc, s_ack;
    logic [N-1:0] s_wr, s_rd, s_rrdy, s_store;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = M_IDLE;
        for (int i = 0; i < N; i++) begin
            m_want[i] = 1'b0; m_issued[i] = 1'b0; m_returned[i] = 1'b0;
        end
    endtask

    task automatic compute_expected();
        e_ctovr_rdy = 1'b0; e_hdr = 1'b0; e_vrtoc = 1'b0; e_ack = 1'b0;
        e_wr = '0; e_rd = '0; e_rrdy = '0; e_store = '0;
        if (rst_n !== 1'b1) return;
        case (m_ph)
            M_IDLE: begin
                e_ctovr_rdy = 1'b1;
                e_hdr       = noc_ctovr_val;
            end
            M_WR: for (int i = 0; i < N; i++) e_wr[i] = m_want[i] && !m_issued[i];
            M_RD: for (int i = 0; i < N; i++) begin
                e_rd[i]    = m_want[i] && !m_issued[i];
                e_rrdy[i]  = m_issued[i] && !m_returned[i];
                e_store[i] = e_rrdy[i] && ptr_rd_resp_val[i];
            end
            M_RSP: e_vrtoc = 1'b1;
            M_ACK: begin e_vrtoc = 1'b1; e_ack = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic model_update();
        int left;
        left = 0;
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        case (m_ph)
            M_IDLE: if (noc_ctovr_val) begin
                for (int i = 0; i < N; i++) begin
                    m_want[i] = noc_ctovr_ptr_mask[i]; m_issued[i] = 1'b0; m_returned[i] = 1'b0;
                end
                if (noc_ctovr_is_rd) m_ph = (noc_ctovr_ptr_mask != '0) ? M_RD : M_RSP;
                else if (noc_ctovr_ptr_mask != '0) m_ph = M_WR;
                else m_ph = ACK_EN ? M_ACK : M_IDLE;
            end
            M_WR: begin
                for (int i = 0; i < N; i++) begin
                    if (e_wr[i] && ptr_wr_req_rdy[i]) m_issued[i] = 1'b1;
                    if (m_want[i] && !m_issued[i]) left++;
                end
                if (left == 0) m_ph = ACK_EN ? M_ACK : M_IDLE;
            end
            M_RD: begin
                for (int i = 0; i < N; i++) begin
                    if (e_store[i]) m_returned[i] = 1'b1;
                    if (e_rd[i] && ptr_rd_req_rdy[i]) m_issued[i] = 1'b1;
                    if (m_want[i] && !m_returned[i]) left++;
                end
                if (left == 0) m_ph = M_RSP;
            end
            M_RSP, M_ACK: if (noc_vrtoc_rdy) begin
                m_flits++;
                m_ph = M_IDLE;
            end
            default: m_ph = M_IDLE;
        endcase
    endtask

    // One clock: sample and compare after the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        @(negedge clk);
        #1;
        compute_expected();
        s_ctovr_rdy = noc_ctovr_rdy;  s_hdr   = ctrl_datap_store_hdr_flit;
        s_vrtoc     = noc_vrtoc_val;  s_ack   = ctrl_datap_resp_is_ack;
        s_wr        = ptr_wr_req_val; s_rd    = ptr_rd_req_val;
        s_rrdy      = ptr_rd_resp_rdy; s_store = ctrl_datap_store_ptr;
        check("ctovr_rdy",   s_ctovr_rdy, e_ctovr_rdy);
        check("store_hdr",   s_hdr,       e_hdr);
        check("vrtoc_val",   s_vrtoc,     e_vrtoc);
        check("resp_is_ack", s_ack,       e_ack);
        check("wr_req_val",  s_wr,        e_wr);
        check("rd_req_val",  s_rd,        e_rd);
        check("rd_resp_rdy", s_rrdy,      e_rrdy);
        check("store_ptr",   s_store,     e_store);
        if (rst_n === 1'b1 && s_vrtoc === 1'b1 && noc_vrtoc_rdy === 1'b1) n_dut_flits++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic val, input logic is_rd, input logic [N-1:0] mask,
                         input logic [N-1:0] wr_rdy, input logic [N-1:0] rd_rdy,
                         input logic [N-1:0] resp_val, input logic vrtoc_rdy);
        noc_ctovr_val      = val;
        noc_ctovr_is_rd    = is_rd;
        noc_ctovr_ptr_mask = mask;
        ptr_wr_req_rdy     = wr_rdy;
        ptr_rd_req_rdy     = rd_rdy;
        ptr_rd_resp_val    = resp_val;
        noc_vrtoc_rdy      = vrtoc_rdy;
    endtask

    initial begin
        int f0;
        int nwr;
        int nwr1;
        model_reset();

        // Reset: all outputs low even with a header offered.
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b11, 1'b1);
        cycle();
        check("reset_ctovr_rdy", s_ctovr_rdy, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 1'b1);
        cycle();
        check("post_reset_ready", s_ctovr_rdy, 1'b1);

        // Read, mask 11, everything ready: latency T..T+4.
        drive(1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b11, 1'b1);
        cycle(); check("rdlat_T_hdr", s_hdr, 1'b1);
        drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 1'b1);
        cycle(); check("rdlat_T1_req", s_rd, 2'b11);
        cycle(); check("rdlat_T2_store", s_store, 2'b11);
        cycle(); check("rdlat_T3_vrtoc", s_vrtoc, 1'b1);
        cycle(); check("rdlat_T4_ready", s_ctovr_rdy, 1'b1);

        // Read, mask 11, table 1 request stalled 3 cycles, table 1 response late.
        f0 = n_dut_flits;
        drive(1'b1, 1'b1, 2'b11, 2'b11, 2'b01, 2'b01, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 2'b01, 1'b1);
        cycle(); check("rdstall_T1_req", s_rd, 2'b11);
        cycle(); check("rdstall_T2_store", s_store, 2'b01);
        cycle(); check("rdstall_T3_store", s_store, 2'b00);
        drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b01, 1'b1);
        cycle(); check("rdstall_T4_req", s_rd, 2'b10);
        cycle(); check("rdstall_T5_rrdy", s_rrdy, 2'b10);
        drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 1'b1);
        cycle(); check("rdstall_T6_store", s_store, 2'b10);
        cycle(); check("rdstall_T7_vrtoc", s_vrtoc, 1'b1);
        cycle(); check("rdstall_flits", n_dut_flits - f0, 1);

        // Write, mask 01, table 0 ready low for 4 cycles.
        f0 = n_dut_flits; nwr = 0; nwr1 = 0;
        drive(1'b1, 1'b0, 2'b01, 2'b00, 2'b11, 2'b11, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k == 4) ptr_wr_req_rdy = 2'b11;
            cycle();
            if (s_wr === 2'b01) nwr++;
            if (s_wr[1] !== 1'b0) nwr1++;
        end
        check("wrstall_held", nwr, 5);
        check("wrstall_tbl1", nwr1, 0);
        check("wrstall_flits", n_dut_flits - f0, ACK_EN ? 1 : 0);
        cycle();

        // Zero-mask read gives an immediate empty response; zero-mask write is dropped.
        drive(1'b1, 1'b1, 2'b00, 2'b11, 2'b11, 2'b11, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 1'b1);
        cycle(); check("rd0_vrtoc", s_vrtoc, 1'b1); check("rd0_noreq", s_rd, 2'b00);
        cycle();
        drive(1'b1, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 1'b1);
        cycle(); check("wr0_ctovr_rdy", s_ctovr_rdy, !ACK_EN); check("wr0_nowr", s_wr, 2'b00);
        cycle();

        // Write, mask 10: ack flit held until vrtoc_rdy when the feature is built in.
        drive(1'b1, 1'b0, 2'b10, 2'b11, 2'b11, 2'b11, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 1'b0);
        cycle(); check("wrack_T1_wr", s_wr, 2'b10);
        cycle(); check("wrack_T2_vrtoc", s_vrtoc, ACK_EN); check("wrack_T2_ack", s_ack, ACK_EN);
        cycle(); check("wrack_T3_hold", s_vrtoc, ACK_EN);
        noc_vrtoc_rdy = 1'b1;
        cycle();
        cycle(); check("wrack_done", s_ctovr_rdy, 1'b1);

        // Asynchronous reset in the middle of a read with table 0 already requested.
        drive(1'b1, 1'b1, 2'b11, 2'b11, 2'b01, 2'b00, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 2'b00, 1'b1);
        cycle();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b11, 1'b1);
        cycle();
        check("rstmid_rd", s_rd, 2'b00);
        check("rstmid_ctovr_rdy", s_ctovr_rdy, 1'b0);
        check("rstmid_hdr", s_hdr, 1'b0);
        rst_n = 1'b1;
        cycle();
        drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 1'b1);
        cycle(); check("rstmid_fresh_req", s_rd, 2'b11);
        cycle(); cycle(); cycle();

        // Random traffic with occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            rst_n              = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            noc_ctovr_val      = ($urandom_range(0, 2) == 0);
            noc_ctovr_is_rd    = $urandom_range(0, 1);
            noc_ctovr_ptr_mask = N'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                ptr_wr_req_rdy[i]  = ($urandom_range(0, 3) != 0);
                ptr_rd_req_rdy[i]  = ($urandom_range(0, 3) != 0);
                ptr_rd_resp_val[i] = ($urandom_range(0, 2) != 0);
            end
            noc_vrtoc_rdy = ($urandom_range(0, 4) < 3);
            cycle();
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 1'b1);
        for (int k = 0; k < 6; k++) cycle();
        check("flit_count", n_dut_flits, m_flits);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
